region_readout_scanner: RTL and testbench
=========================================

// Module: region_readout_scanner
// PURPOSE
//  Reads the oscillator count memories of the logic regions through their read
//  port (5-bit address in, 24-bit data out) and forwards every word as a tagged
//  stream toward the readout network.
//  One address bus is broadcast to all regions. The scanner walks region 0..NumRegion-1,
//  address 0..NumOsc-1, and delivers words over a valid/ready handshake.
// PARAMETERS
//  NumRegion  4   regions scanned; RegW = max(1,$clog2(NumRegion))
//  NumOsc     10  words per region (1..32); addresses 0..NumOsc-1
//  RdLatency  1   cycles from Addr_o change to valid Data_i (legal 0..3)
// PORTS
//  clk      in   1              single clock, all state on rising edge
//  rstn     in   1              asynchronous active-low reset
//  Start_i  in   1              pulse: begin one full scan
//  Addr_o   out  5              read address broadcast to all regions
//  Data_i   in   24*NumRegion   region r data on [24*r +: 24]
//  Valid_o  out  1              stream word valid
//  Ready_i  in   1              downstream accepts word
//  Data_o   out  24             captured count word
//  Tag_o    out  RegW+5         {region index, address} of Data_o
//  Busy_o   out  1              scan in progress (state != IDLE)
//  Done_o   out  1              1-cycle pulse after last word transferred
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE; Addr_o=0, Valid_o=0, Data_o=0, Tag_o=0,
//   Busy_o=0, Done_o=0; region/address/wait counters=0.
//  FSM states IDLE, ADDR, WAIT, HOLD:
//   IDLE: Start_i=1 -> ADDR, reg=0, addr=0. Start_i while not IDLE is ignored.
//   ADDR: Addr_o holds addr (registered; loaded on the entering edge).
//    Lasts 1 cycle. Goes to WAIT if RdLatency>0, else to HOLD with capture.
//   WAIT: counts RdLatency cycles. On the edge leaving the last WAIT cycle:
//    Data_o <= Data_i[24*reg +: 24], Tag_o <= {reg,addr}, then -> HOLD.
//   HOLD: Valid_o=1. Data_o, Tag_o and Valid_o stay stable until Valid_o&&Ready_i.
//    On transfer:
//     - if addr<NumOsc-1: addr++ -> ADDR.
//     - else if reg<NumRegion-1: reg++, addr=0 -> ADDR.
//     - else: -> IDLE and Done_o=1 for the next cycle.
//  Capture timing: data is sampled exactly 1+RdLatency cycles after Addr_o is loaded.
//   Valid_o is deasserted for at least 1+RdLatency cycles between words.
//   Throughput is at best one word per RdLatency+2 cycles.
//  Valid_o is a registered output; it is high only in HOLD.
//  Ready_i is allowed high before Valid_o; it is ignored outside HOLD.
//  Busy_o=1 from the cycle after Start_i until the cycle Done_o is asserted.
//   Busy_o=0 in the Done_o cycle.
//  Addr_o keeps its last value while IDLE; it does not return to 0 after a scan.
//  Counters are sized RegW and 5 bits. Wrap beyond NumOsc-1 / NumRegion-1
//   never occurs; the terminal compare ends the scan.
//  No coherence with concurrent RAM writes: each word reflects the RAM content
//   at its own capture cycle.
//  Reset mid-scan aborts immediately. The partial word is dropped and Done_o
//   is not pulsed.
// TESTING
//  1 NumRegion=2, NumOsc=3, RdLatency=1, Ready_i=1, region r addr a returns
//    0x100*r+a, pulse Start_i -> 6 words 0x000,0x001,0x002,0x100,0x101,0x102
//    with tags {0,0}..{1,2}, each Valid_o 1 cycle, word spacing 3 cycles,
//    Done_o once after the 6th word.
//  2 Ready_i=0 for 5 cycles during the 2nd word -> Valid_o held 5+ cycles,
//    Data_o/Tag_o unchanged, no word lost or duplicated, total count still 6.
//  3 RdLatency=0 (combinational RAM) and RdLatency=3 -> correct data per tag,
//    word spacing 2 and 5 cycles respectively.
//  4 Start_i pulsed again mid-scan -> ignored; exactly one Done_o and
//    NumRegion*NumOsc words.
//  5 rstn low while in HOLD -> Valid_o/Busy_o drop at once, outputs reset
//    values; a new Start_i runs a full clean scan from {0,0}.
//  6 NumOsc=32, NumRegion=1 -> addresses 0..31 with no wrap, Done_o after
//    addr 31.

Source files
------------

// File: rtl/region_readout_scanner.sv
// Walks every region's count memory word by word through the shared read port
// and forwards each word, tagged with {region, address}, over valid/ready.
module region_readout_scanner #(
  parameter int unsigned NumRegion = 4,
  parameter int unsigned NumOsc    = 10,
  parameter int unsigned RdLatency = 1,
  localparam int unsigned RegW     = (NumRegion > 1) ? $clog2(NumRegion) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    Start_i,
  output logic [4:0]              Addr_o,
  input  logic [24*NumRegion-1:0] Data_i,
  output logic                    Valid_o,
  input  logic                    Ready_i,
  output logic [23:0]             Data_o,
  output logic [RegW+4:0]         Tag_o,
  output logic                    Busy_o,
  output logic                    Done_o
);

  localparam int unsigned AddrW = 5;
  localparam int unsigned WordW = 24;
  localparam int unsigned WaitW = 2;
  localparam logic [AddrW-1:0] AddrLast = AddrW'(NumOsc - 1);
  localparam logic [RegW-1:0]  RegLast  = RegW'(NumRegion - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'((RdLatency > 0) ? RdLatency - 1 : 0);

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StWait,
    StHold
  } state_t;

  state_t                state, stateNext;
  logic [RegW-1:0]       regCnt, regNext;
  logic [WaitW-1:0]      waitCnt, waitNext;
  logic [AddrW-1:0]      addrNext;
  logic [WordW-1:0]      dataNext;
  logic [RegW+AddrW-1:0] tagNext;
  logic                  validNext, busyNext, doneNext;
  logic                  captureC;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= StIdle;
      regCnt  <= '0;
      waitCnt <= '0;
      Addr_o  <= '0;
      Data_o  <= '0;
      Tag_o   <= '0;
      Valid_o <= 1'b0;
      Busy_o  <= 1'b0;
      Done_o  <= 1'b0;
    end else begin
      state   <= stateNext;
      regCnt  <= regNext;
      waitCnt <= waitNext;
      Addr_o  <= addrNext;
      Data_o  <= dataNext;
      Tag_o   <= tagNext;
      Valid_o <= validNext;
      Busy_o  <= busyNext;
      Done_o  <= doneNext;
    end
  end

  // Next-state, counters and output values
  always_comb begin
    stateNext = state;
    regNext   = regCnt;
    waitNext  = waitCnt;
    addrNext  = Addr_o;
    dataNext  = Data_o;
    tagNext   = Tag_o;
    validNext = Valid_o;
    doneNext  = 1'b0;
    captureC  = 1'b0;

    case (state)
      StIdle: begin
        if (Start_i) begin
          stateNext = StAddr;
          regNext   = '0;
          addrNext  = '0;
        end
      end
      StAddr: begin
        waitNext = '0;
        if (RdLatency == 0) begin
          stateNext = StHold;
          captureC  = 1'b1;
        end else begin
          stateNext = StWait;
        end
      end
      StWait: begin
        if (waitCnt == WaitLast) begin
          stateNext = StHold;
          captureC  = 1'b1;
        end else begin
          waitNext = waitCnt + 1'b1;
        end
      end
      StHold: begin
        if (Ready_i) begin
          validNext = 1'b0;
          if (Addr_o != AddrLast) begin
            addrNext  = Addr_o + 1'b1;
            stateNext = StAddr;
          end else if (regCnt != RegLast) begin
            regNext   = regCnt + 1'b1;
            addrNext  = '0;
            stateNext = StAddr;
          end else begin
            stateNext = StIdle;
            doneNext  = 1'b1;
          end
        end
      end
      default: stateNext = StIdle;
    endcase

    // Sample the selected region exactly 1+RdLatency cycles after the address
    if (captureC) begin
      dataNext  = Data_i[WordW*regCnt +: WordW];
      tagNext   = {regCnt, Addr_o};
      validNext = 1'b1;
    end

    busyNext = (stateNext != StIdle);
  end

endmodule

// File: tb/tb_region_readout_scanner.sv
// Directed bench: four scanner instances (latency 1/0/3 and a 32-word single
// region) read from behavioural memories returning 0x100*region+address.
module tb_region_readout_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [3:0]  start;
  logic        ready0, readyHi;

  logic [4:0]  addr0, addr1, addr2, addr3;
  logic [47:0] din0, din1, din2;
  logic [23:0] din3;
  logic [23:0] dout0, dout1, dout2, dout3;
  logic [5:0]  tag0, tag1, tag2, tag3;
  logic        valid0, valid1, valid2, valid3;
  logic        busy0, busy1, busy2, busy3;
  logic        done0, done1, done2, done3;

  region_readout_scanner #(.NumRegion(2), .NumOsc(3), .RdLatency(1)) u0 (
    .clk(clk), .rstn(rstn), .Start_i(start[0]), .Addr_o(addr0), .Data_i(din0),
    .Valid_o(valid0), .Ready_i(ready0), .Data_o(dout0), .Tag_o(tag0),
    .Busy_o(busy0), .Done_o(done0));
  region_readout_scanner #(.NumRegion(2), .NumOsc(3), .RdLatency(0)) u1 (
    .clk(clk), .rstn(rstn), .Start_i(start[1]), .Addr_o(addr1), .Data_i(din1),
    .Valid_o(valid1), .Ready_i(readyHi), .Data_o(dout1), .Tag_o(tag1),
    .Busy_o(busy1), .Done_o(done1));
  region_readout_scanner #(.NumRegion(2), .NumOsc(3), .RdLatency(3)) u2 (
    .clk(clk), .rstn(rstn), .Start_i(start[2]), .Addr_o(addr2), .Data_i(din2),
    .Valid_o(valid2), .Ready_i(readyHi), .Data_o(dout2), .Tag_o(tag2),
    .Busy_o(busy2), .Done_o(done2));
  region_readout_scanner #(.NumRegion(1), .NumOsc(32), .RdLatency(1)) u3 (
    .clk(clk), .rstn(rstn), .Start_i(start[3]), .Addr_o(addr3), .Data_i(din3),
    .Valid_o(valid3), .Ready_i(readyHi), .Data_o(dout3), .Tag_o(tag3),
    .Busy_o(busy3), .Done_o(done3));

  function automatic logic [47:0] ramWord(input logic [4:0] a);
    return {24'h100 + 24'(a), 24'(a)};
  endfunction

  // Memories with the read latency each instance expects
  logic [4:0] a2p1, a2p2, a2p3, a3p1;
  always @(posedge clk) begin
    din0 <= ramWord(addr0);
    a2p1 <= addr2;
    a2p2 <= a2p1;
    a2p3 <= a2p2;
    a3p1 <= addr3;
  end
  assign din1 = ramWord(addr1);
  assign din2 = ramWord(a2p3);
  assign din3 = 24'(a3p1);

  typedef struct {
    int inst;
    int data;
    int tag;
    int cyc;
  } xfer_t;

  xfer_t       q[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          doneCnt[4], doneCyc[4], validCnt[4];
  logic        prevHeld[4];
  logic [31:0] prevData[4], prevTag[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Logs transfers and checks that a stalled word stays put
  task automatic record(input int i, input logic v, input logic rdy, input logic [31:0] d,
                        input logic [31:0] t, input logic dn, input logic bz);
    if (!rstn) begin
      prevHeld[i] = 1'b0;
      return;
    end
    if (prevHeld[i]) begin
      check($sformatf("u%0d_hold_valid", i), 32'(v), 32'd1);
      check($sformatf("u%0d_hold_data", i), d, prevData[i]);
      check($sformatf("u%0d_hold_tag", i), t, prevTag[i]);
    end
    if (v) validCnt[i]++;
    if (v && rdy) q.push_back('{i, int'(d), int'(t), cyc});
    if (dn) begin
      doneCnt[i]++;
      doneCyc[i] = cyc;
      check($sformatf("u%0d_busy_in_done", i), 32'(bz), 32'd0);
    end
    prevHeld[i] = v && !rdy;
    prevData[i] = d;
    prevTag[i]  = t;
  endtask

  always @(negedge clk) begin
    #1;
    record(0, valid0, ready0,  32'(dout0), 32'(tag0), done0, busy0);
    record(1, valid1, readyHi, 32'(dout1), 32'(tag1), done1, busy1);
    record(2, valid2, readyHi, 32'(dout2), 32'(tag2), done2, busy2);
    record(3, valid3, readyHi, 32'(dout3), 32'(tag3), done3, busy3);
  end

  task automatic clearLog();
    q.delete();
    for (int i = 0; i < 4; i++) begin
      doneCnt[i]  = 0;
      doneCyc[i]  = 0;
      validCnt[i] = 0;
      prevHeld[i] = 1'b0;
    end
  endtask

  task automatic pulseStart(input logic [3:0] mask);
    @(negedge clk) start = mask;
    @(negedge clk) start = 4'h0;
  endtask

  task automatic waitDone(input int i, input int budget);
    int n = 0;
    while (doneCnt[i] == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d_done_seen", i), 32'(doneCnt[i] != 0), 32'd1);
  endtask

  task automatic waitValid0(input int words, input int budget);
    int n = 0;
    while (!(valid0 && q.size() == words) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("u0_valid_seen", 32'(valid0), 32'd1);
  endtask

  // Word order, data, tag, spacing and single Done pulse for one instance
  task automatic checkScan(input int i, input int nReg, input int nOsc,
                           input int spacing, input int validExp);
    int k = 0;
    int lastCyc = 0;
    foreach (q[j]) begin
      if (q[j].inst == i) begin
        check($sformatf("u%0d_data_w%0d", i, k), 32'(q[j].data), 32'('h100 * (k / nOsc) + k % nOsc));
        check($sformatf("u%0d_tag_w%0d", i, k), 32'(q[j].tag), 32'(32 * (k / nOsc) + k % nOsc));
        if (k > 0 && spacing > 0)
          check($sformatf("u%0d_spacing_w%0d", i, k), 32'(q[j].cyc - lastCyc), 32'(spacing));
        lastCyc = q[j].cyc;
        k++;
      end
    end
    check($sformatf("u%0d_word_count", i), 32'(k), 32'(nReg * nOsc));
    check($sformatf("u%0d_done_count", i), 32'(doneCnt[i]), 32'd1);
    check($sformatf("u%0d_done_cycle", i), 32'(doneCyc[i]), 32'(lastCyc + 1));
    check($sformatf("u%0d_valid_cycles", i), 32'(validCnt[i]), 32'(validExp));
  endtask

  initial begin
    rstn    = 1'b0;
    start   = 4'h0;
    ready0  = 1'b1;
    readyHi = 1'b1;
    clearLog();
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr0), 32'd0);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_data", 32'(dout0), 32'd0);
    check("rst_tag", 32'(tag0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    rstn = 1'b1;

    // Basic scan on all instances: latency 1, 0, 3 and the 32-word region
    clearLog();
    @(negedge clk) start = 4'hF;
    @(negedge clk) begin
      check("busy_after_start", 32'({busy3, busy2, busy1, busy0}), 32'hF);
      start = 4'h0;
    end
    waitDone(0, 60);
    waitDone(1, 60);
    waitDone(2, 100);
    waitDone(3, 300);
    repeat (2) @(negedge clk);
    checkScan(0, 2, 3, 3, 6);
    checkScan(1, 2, 3, 2, 6);
    checkScan(2, 2, 3, 5, 6);
    checkScan(3, 1, 32, 3, 32);
    check("u0_addr_kept", 32'(addr0), 32'd2);
    check("u3_addr_kept", 32'(addr3), 32'd31);
    check("u0_idle_busy", 32'(busy0), 32'd0);

    // Backpressure for 5 cycles on the second word
    clearLog();
    pulseStart(4'h1);
    waitValid0(1, 50);
    ready0 = 1'b0;
    repeat (5) @(negedge clk);
    ready0 = 1'b1;
    waitDone(0, 80);
    repeat (2) @(negedge clk);
    checkScan(0, 2, 3, 0, 11);

    // Second Start mid-scan is ignored
    clearLog();
    pulseStart(4'h1);
    repeat (6) @(negedge clk);
    pulseStart(4'h1);
    waitDone(0, 80);
    repeat (4) @(negedge clk);
    checkScan(0, 2, 3, 3, 6);
    check("u0_no_restart", 32'(busy0), 32'd0);

    // Reset while holding the second word, then a clean rescan
    clearLog();
    pulseStart(4'h1);
    waitValid0(1, 50);
    ready0 = 1'b0;
    @(negedge clk);
    check("pre_abort_data", 32'(dout0), 32'h1);
    rstn = 1'b0;
    #1;
    check("abort_valid", 32'(valid0), 32'd0);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_data", 32'(dout0), 32'd0);
    check("abort_tag", 32'(tag0), 32'd0);
    check("abort_addr", 32'(addr0), 32'd0);
    check("abort_done", 32'(done0), 32'd0);
    @(negedge clk);
    rstn   = 1'b1;
    ready0 = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(doneCnt[0]), 32'd0);
    check("abort_no_word", 32'(q.size()), 32'd1);
    clearLog();
    pulseStart(4'h1);
    waitDone(0, 60);
    repeat (2) @(negedge clk);
    checkScan(0, 2, 3, 3, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
